// File: rtl/spi_xfer_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_xfer_seq_if
// Brief    : Command, TX/RX stream and byte-master bundle for spi_xfer_seq.
// Revision : 1.0
// ============================================================================
interface spi_xfer_seq_if #(
    parameter int LEN_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       tx_data;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             rx_last;
    logic             done;
    logic             cs_n;
    logic             spi_start;
    logic [7:0]       spi_data_in;
    logic             spi_busy;
    logic             spi_new_data;
    logic [7:0]       spi_data_out;

    // master: the requester plus byte-level SPI master; slave: the sequencer
    modport master (
        output cmd_valid, cmd_len, tx_valid, tx_data,
               spi_busy, spi_new_data, spi_data_out,
        input  cmd_ready, tx_ready, rx_valid, rx_data, rx_last, done,
               cs_n, spi_start, spi_data_in
    );

    modport slave (
        input  cmd_valid, cmd_len, tx_valid, tx_data,
               spi_busy, spi_new_data, spi_data_out,
        output cmd_ready, tx_ready, rx_valid, rx_data, rx_last, done,
               cs_n, spi_start, spi_data_in
    );
endinterface
`default_nettype wire

// File: rtl/spi_xfer_seq.sv
`default_nettype none
// ============================================================================
// Module   : spi_xfer_seq
// Brief    : Multi-byte SPI burst sequencer driving a byte-level SPI master,
//            with programmable chip-select setup and hold.
// Revision : 1.0
// ============================================================================
module spi_xfer_seq #(
    parameter int LEN_W    = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic          clk,
    input  logic          rst,
    spi_xfer_seq_if.slave bus
);
    localparam int c_CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(CS_SETUP - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_LOAD  = 3'd2,
        S_XFER  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_byte_cnt;
    logic [c_CNT_W-1:0] r_cyc_cnt;
    logic               r_cs_n;
    logic               r_rx_valid;
    logic [7:0]         r_rx_data;
    logic               r_rx_last;
    logic               r_done;

    logic w_tx_ready;
    logic w_start;

    // Handshake outputs are gated by rst so they read 0 while reset is held
    assign w_tx_ready      = rst && (r_state == S_LOAD) && !bus.spi_busy;
    assign w_start         = w_tx_ready && bus.tx_valid;
    assign bus.tx_ready    = w_tx_ready;
    assign bus.spi_start   = w_start;
    assign bus.spi_data_in = w_start ? bus.tx_data : 8'h00;
    assign bus.cmd_ready   = rst && (r_state == S_IDLE);
    assign bus.cs_n        = r_cs_n;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_last     = r_rx_last;
    assign bus.done        = r_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_cyc_cnt  <= '0;
            r_cs_n     <= 1'b1;
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_last  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_last  <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_len      <= bus.cmd_len;
                        r_byte_cnt <= '0;
                        r_cyc_cnt  <= '0;
                        r_cs_n     <= 1'b0;
                        r_state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cyc_cnt == c_SETUP_LAST) begin
                        r_cyc_cnt <= '0;
                        r_state   <= S_LOAD;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_start) begin
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    // Only new_data advances; busy from the master is not consulted here
                    if (bus.spi_new_data) begin
                        r_rx_valid <= 1'b1;
                        r_rx_data  <= bus.spi_data_out;
                        r_rx_last  <= (r_byte_cnt == r_len);
                        if (r_byte_cnt == r_len) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            r_state    <= S_LOAD;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_cyc_cnt == c_HOLD_LAST) begin
                        r_cyc_cnt <= '0;
                        r_cs_n    <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cyc_cnt <= r_cyc_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_xfer_seq
// Brief    : Randomized bench for spi_xfer_seq with a behavioural SPI master
//            and a burst-level reference model (queues of expected bytes).
// Revision : 1.0
// ============================================================================
module tb_spi_xfer_seq;
    localparam int LEN_W    = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    spi_xfer_seq_if #(.LEN_W(LEN_W)) bus ();

    spi_xfer_seq #(.LEN_W(LEN_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    int         exp_len[$];

    bit linger_en  = 0;
    bit b2b_chk    = 0;
    bit spur_nd    = 0;
    bit m_pending  = 0;
    int byte_t_max = 3;
    int bursts_done = 0;
    int bursts_exp  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Byte-level SPI master: busy for a random byte time, then a new_data pulse
    initial begin : g_master
        int m_cnt;
        int m_linger;
        m_cnt = 0;
        m_linger = 0;
        bus.spi_busy = 1'b0;
        bus.spi_new_data = 1'b0;
        bus.spi_data_out = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus.spi_new_data = 1'b0;
            if (!rst_n) begin
                bus.spi_busy = 1'b0;
                m_cnt = 0;
                m_linger = 0;
                m_pending = 0;
            end else if (m_pending) begin
                m_pending = 0;
                bus.spi_busy = 1'b1;
                m_cnt = $urandom_range(1, byte_t_max);
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    bus.spi_new_data = 1'b1;
                    bus.spi_data_out = 8'($urandom);
                    exp_rx.push_back(bus.spi_data_out);
                    if (linger_en && $urandom_range(0, 2) == 0) m_linger = $urandom_range(2, 3);
                    else bus.spi_busy = 1'b0;
                end
            end else if (m_linger > 0) begin
                m_linger--;
                if (m_linger == 0) bus.spi_busy = 1'b0;
            end else if (spur_nd) begin
                spur_nd = 0;
                bus.spi_new_data = 1'b1;
                bus.spi_data_out = 8'hEE;
            end
        end
    end

    // Burst-level monitor: cs_n framing, byte order, last tagging, setup/hold
    initial begin : g_monitor
        bit prev_cs, started, holding, nd_prev;
        int gap, setup_cnt, hold_cnt, starts, rxs, cur_len;
        prev_cs = 1; started = 0; holding = 0; nd_prev = 0;
        gap = 100; setup_cnt = 0; hold_cnt = 0; starts = 0; rxs = 0; cur_len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_cs = 1; started = 0; holding = 0; nd_prev = 0; gap = 100;
                continue;
            end
            if (!bus.cs_n && prev_cs) begin
                chk("cs_gap", 32'(gap >= 1), 1);
                chk("len_known", 32'(exp_len.size() > 0), 1);
                cur_len = (exp_len.size() > 0) ? exp_len.pop_front() : 0;
                starts = 0; rxs = 0; started = 0; setup_cnt = 0; holding = 0;
            end
            gap = bus.cs_n ? gap + 1 : 0;
            chk("cmd_ready", bus.cmd_ready, bus.cs_n);
            chk("done", bus.done, bus.cs_n & ~prev_cs);
            if (bus.spi_start) begin
                chk("start_cs", bus.cs_n, 0);
                chk("start_busy", bus.spi_busy, 0);
                chk("tx_known", 32'(exp_tx.size() > 0), 1);
                if (exp_tx.size() > 0) chk("data_in", bus.spi_data_in, exp_tx.pop_front());
                if (!started) chk("setup", setup_cnt, CS_SETUP);
                started = 1;
                starts++;
                m_pending = 1;
            end else begin
                chk("data_in_idle", bus.spi_data_in, 0);
                if (!bus.cs_n && !started) setup_cnt++;
            end
            if (b2b_chk && nd_prev) chk("b2b", bus.spi_start, 1);
            nd_prev = bus.spi_new_data && !bus.cs_n && started && (rxs < cur_len);
            if (bus.rx_valid) begin
                chk("rx_cs", bus.cs_n, 0);
                chk("rx_known", 32'(exp_rx.size() > 0), 1);
                if (exp_rx.size() > 0) chk("rx_data", bus.rx_data, exp_rx.pop_front());
                chk("rx_last", bus.rx_last, 32'(rxs == cur_len));
                rxs++;
                if (bus.rx_last) begin
                    holding = 1;
                    hold_cnt = 1;
                end
            end else if (holding && !bus.cs_n) begin
                hold_cnt++;
            end
            if (bus.cs_n && !prev_cs) begin
                chk("hold", hold_cnt, CS_HOLD);
                chk("n_starts", starts, cur_len + 1);
                chk("n_rx", rxs, cur_len + 1);
                holding = 0;
                bursts_done++;
            end
            prev_cs = bus.cs_n;
        end
    end

    task automatic issue(input int len);
        exp_len.push_back(len);
        bus.cmd_valid = 1'b1;
        bus.cmd_len = LEN_W'(len);
    endtask

    task automatic wait_cmd();
        bit ok = 0;
        int t = 0;
        while (!ok && t < 2000) begin
            @(negedge clk);
            if (bus.cmd_valid && bus.cmd_ready) ok = 1;
            t++;
        end
        chk("cmd_wait", 32'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int gap, input logic [7:0] d);
        bit ok = 0;
        int t = 0;
        bus.tx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.tx_valid = 1'b1;
        bus.tx_data = d;
        exp_tx.push_back(d);
        while (!ok && t < 500) begin
            @(negedge clk);
            if (bus.tx_valid && bus.tx_ready) ok = 1;
            t++;
        end
        chk("tx_hs_wait", 32'(ok), 1);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_bursts();
        int t = 0;
        bursts_exp++;
        while (bursts_done < bursts_exp && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("done_wait", 32'(bursts_done >= bursts_exp), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_burst(input int len, input int max_gap);
        issue(len);
        wait_cmd();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i <= len; i++)
            send_byte((i == 0) ? 0 : $urandom_range(0, max_gap), 8'($urandom));
        wait_bursts();
    endtask

    initial begin : g_watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : g_main
        bit ok;
        int t;
        bus.cmd_valid = 1'b0;
        bus.cmd_len = '0;
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", bus.cs_n, 1);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_rx_last", bus.rx_last, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_tx_ready", bus.tx_ready, 0);
        chk("rst_start", bus.spi_start, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_cmd_ready", bus.cmd_ready, 1);

        // Single byte
        issue(0);
        wait_cmd();
        bus.cmd_valid = 1'b0;
        send_byte(0, 8'hA5);
        wait_bursts();

        // Three bytes, 5-cycle TX gap before byte 2, master busy may linger
        linger_en = 1;
        issue(2);
        wait_cmd();
        bus.cmd_valid = 1'b0;
        send_byte(0, 8'h01);
        send_byte(5, 8'h02);
        send_byte(0, 8'h03);
        wait_bursts();

        // Maximum length
        run_burst(15, 0);

        // Second command held pending through the first burst
        issue(3);
        wait_cmd();
        issue(1);
        for (int i = 0; i < 4; i++) send_byte(0, 8'($urandom));
        wait_cmd();
        bus.cmd_valid = 1'b0;
        send_byte(0, 8'($urandom));
        send_byte(0, 8'($urandom));
        wait_bursts();
        bursts_exp++;

        // Reset while byte 2 of a 4-byte burst is being started
        linger_en = 0;
        issue(3);
        wait_cmd();
        bus.cmd_valid = 1'b0;
        send_byte(0, 8'($urandom));
        ok = 0;
        t = 0;
        while (!ok && t < 200) begin
            @(negedge clk);
            if (bus.tx_ready) ok = 1;
            t++;
        end
        chk("load_wait", 32'(ok), 1);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b1;
        bus.tx_data = 8'h5A;
        #1;
        chk("pre_rst_start", bus.spi_start, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_cs_n", bus.cs_n, 1);
        chk("arst_start", bus.spi_start, 0);
        chk("arst_tx_ready", bus.tx_ready, 0);
        chk("arst_cmd_ready", bus.cmd_ready, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_rx_last", bus.rx_last, 0);
        repeat (3) @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        exp_tx.delete();
        exp_rx.delete();
        exp_len.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);
        run_burst(0, 0);

        // Back-to-back bytes, plus a stray new_data while idle
        b2b_chk = 1;
        run_burst(7, 0);
        b2b_chk = 0;
        spur_nd = 1;
        repeat (4) @(posedge clk);
        #1;

        // Randomized bursts
        linger_en = 1;
        for (int k = 0; k < 8; k++) run_burst($urandom_range(0, 15), 3);

        repeat (5) @(posedge clk);
        chk("final_bursts", bursts_done, bursts_exp);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spi_xfer_seq.md
Name: spi_xfer_seq

Overview:
- Multi-byte SPI transaction sequencer that sits directly upstream of the byte-level SPI master.
- Accepts a command (burst length) and a TX byte stream, then asserts chip-select with programmable setup/hold.
- Issues one start pulse per byte to the SPI master and returns each received byte on an RX stream tagged with last.
- Lets software and other blocks run N-byte SPI transactions without per-byte control.

Parameters:
- LEN_W, 4, width of cmd_len; burst is 1..2^LEN_W bytes.
- CS_SETUP, 2, clk cycles cs_n is low before first spi_start (>=1).
- CS_HOLD, 2, clk cycles cs_n stays low after last spi_new_data (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge.
- cmd_len  in  LEN_W  burst length minus one.
- tx_valid  in  1  TX byte available.
- tx_ready  out  1  TX byte consumed when tx_valid & tx_ready.
- tx_data  in  8  TX byte.
- rx_valid  out  1  one-cycle pulse, RX byte valid; no backpressure.
- rx_data  out  8  received byte.
- rx_last  out  1  qualifies rx_valid: final byte of burst.
- done  out  1  one-cycle pulse after cs_n deasserts.
- cs_n  out  1  active-low chip select.
- spi_start  out  1  to master start.
- spi_data_in  out  8  to master data_in.
- spi_busy  in  1  from master busy.
- spi_new_data  in  1  from master new_data.
- spi_data_out  in  8  from master data_out.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values: cs_n=1, rx_valid=0, rx_data=0, rx_last=0, done=0, state=IDLE, counters=0.
- Combinational outputs forced by reset: spi_start=0, tx_ready=0, cmd_ready=0 while rst low.
- States: IDLE, SETUP, LOAD, XFER, HOLD.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch cmd_len into len_q, clear byte counter, register cs_n<=0, go SETUP.
- SETUP:
  - Count CS_SETUP cycles (cs_n low throughout), then go LOAD.
  - First spi_start possible on the cycle after the last SETUP cycle.
- LOAD:
  - tx_ready = !spi_busy (combinational, LOAD only).
  - spi_start = tx_valid & tx_ready; spi_data_in = tx_data (combinational pass-through, valid only while spi_start=1, else 0).
  - On handshake, go XFER. If tx_valid stays low, wait indefinitely with cs_n held low (no timeout).
- XFER:
  - tx_ready=0, spi_start=0.
  - On spi_new_data: rx_valid<=1, rx_data<=spi_data_out, rx_last<=(byte_cnt==len_q).
  - If last, go HOLD; else byte_cnt+1 and go LOAD.
  - spi_busy is ignored in XFER; only spi_new_data advances.
- HOLD:
  - Count CS_HOLD cycles, then cs_n<=1, done<=1 for one cycle, go IDLE.
  - cmd_ready rises the cycle cs_n goes high, so the minimum cs_n-high gap between bursts is 1 cycle.
- Counters:
  - byte_cnt is LEN_W bits and compares against len_q; cmd_len = 2^LEN_W-1 gives 2^LEN_W bytes with no early wrap.
  - Setup/hold counter width is sized for max(CS_SETUP, CS_HOLD).
- Concurrency rules:
  - cmd_valid outside IDLE is ignored (cmd_ready=0); the command is not queued.
  - tx_valid outside LOAD is ignored.
  - spi_new_data outside XFER is ignored.
- Reset mid-burst: cs_n returns to 1 immediately (async), and the partial RX burst produces no rx_last and no done.
- Byte latency: spi_start to rx_valid = master byte time + 1 cycle (rx_valid registered).

Test Plan:
- Single byte: cmd_len=0, tx 0xA5, master model loops miso=0x3C. Expect:
  - cs_n low 2 cycles before spi_start, one spi_start with spi_data_in=0xA5.
  - rx_valid with rx_data=0x3C and rx_last=1.
  - cs_n high 2 cycles after new_data, done 1 cycle.
- 3-byte burst with TX gap: cmd_len=2, tx 0x01/0x02/0x03 with tx_valid low 5 cycles before byte 2. Expect:
  - cs_n continuously low, exactly 3 spi_start pulses, no start while spi_busy=1.
  - rx_last only on the 3rd rx_valid.
- Max length: cmd_len=15. Expect exactly 16 spi_start and 16 rx_valid pulses, rx_last on the 16th, and done once.
- Command while busy: cmd_valid held high through the burst with a second cmd_len=1. Expect:
  - cmd_ready=0 until after done; second burst starts only after cs_n has been high >=1 cycle.
  - Second burst has 2 bytes.
- Reset mid-burst: assert rst low during byte 2 of a 4-byte burst. Expect:
  - cs_n=1 and spi_start=0 asynchronously; no done, no rx_last.
  - After release, cmd_ready=1 and a fresh cmd_len=0 burst completes normally.
- Back-to-back bytes: tx_valid permanently high, CS_SETUP=1, CS_HOLD=1. Expect each spi_start on the cycle after the spi_new_data that completed the previous byte, i.e. exactly one LOAD cycle per byte.
